// File: rtl/seven_seg_pkg.sv
// Shared types, segment constants and helpers for the multiplexed seven-segment display.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    // Segment order is {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    function automatic logic [6:0] seg_decode(input bcd_t digit);
        case (digit)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle, MSB first.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [VALUE_W-1:0]          value,
    output logic                        busy,
    output logic                        done,
    output bcd_t [NUM_DIGITS-1:0]       bcd,
    output logic                        overflow
);

    localparam int          CNT_W = $clog2(VALUE_W);
    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic [VALUE_W-1:0]    r_bin;
    bcd_t [NUM_DIGITS-1:0] r_bcd;
    logic                  r_ovf;

    bcd_t [NUM_DIGITS-1:0] w_adj;
    bcd_t [NUM_DIGITS-1:0] w_next;
    logic                  w_last;

    always_comb begin
        // NOTE: default assignment first so every path drives w_adj; otherwise a latch is inferred
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i] >= 4'd5) w_adj[i] = r_bcd[i] + 4'd3;
        end
    end

    // The carry out of the top nibble is dropped; overflow already flags that range
    assign w_next = BCD_W'({w_adj, r_bin[VALUE_W-1]});
    assign w_last = (r_cnt == CNT_W'(VALUE_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_bcd  <= '0;
            r_ovf  <= 1'b0;
        end else if (!r_busy) begin
            if (start) begin
                // NOTE: non-blocking assignments so every register samples pre-edge values
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_bin  <= value;
                r_bcd  <= '0;
                r_ovf  <= (64'(value) >= LIMIT);
            end
        end else begin
            r_bin <= r_bin << 1;
            r_bcd <= w_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_busy <= 1'b0;
        end
    end

    // The final shift result is handed out combinationally so the commit lands on that same edge
    assign busy     = r_busy;
    assign done     = r_busy && w_last;
    assign bcd      = w_next;
    assign overflow = r_ovf;

endmodule

// File: rtl/seven_seg_mux_display.sv
// Multi-digit time-multiplexed seven-segment driver with blanking, blink and overflow dash.
module seven_seg_mux_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic                  w_busy;
    logic                  w_done;
    logic                  w_pend_ovf;
    bcd_t [NUM_DIGITS-1:0] w_bcd;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (load),
        .value    (value),
        .busy     (w_busy),
        .done     (w_done),
        .bcd      (w_bcd),
        .overflow (w_pend_ovf)
    );

    bcd_t [NUM_DIGITS-1:0] r_digits;
    logic                  r_ovf;
    logic [REF_W-1:0]      r_refresh;
    logic [IDX_W-1:0]      r_index;
    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_phase_on;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_wrap;
    logic [NUM_DIGITS-1:0] w_lz_mask;
    bcd_t                  w_digit;
    logic [6:0]            w_seg;

    assign w_wrap  = (r_refresh == REF_W'(REFRESH_DIV - 1));
    assign w_digit = r_digits[r_index];

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is
    always_comb begin
        logic zero_above;
        w_lz_mask  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (r_digits[i] == 4'd0);
            w_lz_mask[i] = zero_above;
        end
    end

    always_comb begin
        w_seg = seg_decode(w_digit);
        if (r_ovf)                              w_seg = SEG_DASH;
        else if (blank_lz && w_lz_mask[r_index]) w_seg = SEG_BLANK;
        if (blink_en && !r_phase_on)            w_seg = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh   <= '0;
            r_index     <= '0;
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + REF_W'(1);
            if (w_wrap) begin
                r_index <= (r_index == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_index + IDX_W'(1);
                if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase_on  <= ~r_phase_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // seg and an are both registered from the same index, so they switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the display register is reset because its contents are visible on the panel
            r_digits <= '0;
            r_ovf    <= 1'b0;
            r_seg    <= seg_decode(4'd0);
            r_an     <= NUM_DIGITS'(1);
        end else begin
            if (w_done) begin
                r_digits <= w_bcd;
                r_ovf    <= w_pend_ovf;
            end
            r_seg <= w_seg;
            r_an  <= NUM_DIGITS'(1) << r_index;
        end
    end

    assign busy     = w_busy;
    assign overflow = r_ovf;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: doc/seven_seg_mux_display.md
# seven_seg_mux_display

Parametrised, time-multiplexed multi-digit seven-segment driver for the vending-machine front panel, replacing the single-digit combinational price decoder. It accepts a binary value such as a price, credit or change amount through a load strobe. It converts the value to BCD sequentially with shift-add-3, then scans the digits onto a shared segment bus with one-hot digit enables. It also supports leading-zero blanking, a blink mode and an overflow indication.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- VALUE_W, 14, binary input width (≥ 4)
- REFRESH_DIV, 100000, clock cycles each digit stays enabled (≥ 2)
- BLINK_TICKS, 250, refresh ticks per blink half-period (≥ 1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- value  in  VALUE_W  binary value to display
- load  in  1  capture value this cycle (ignored while busy)
- blank_lz  in  1  blank leading zero digits
- blink_en  in  1  enable blinking of the whole display
- busy  out  1  conversion in progress
- overflow  out  1  last accepted value ≥ 10^NUM_DIGITS
- seg  out  7  segments {g,f,e,d,c,b,a}, active high, registered
- an  out  NUM_DIGITS  one-hot digit enable, active high, registered; bit 0 is the least significant digit

## Operation
- Load: at a rising edge with load=1 and busy=0, capture value, clear the shift register and set busy. With busy=1, load is ignored and no value is queued.
- Range check at capture: if value ≥ 10^NUM_DIGITS, set the pending overflow flag.
- Conversion: double-dabble, one input bit per cycle, MSB first. Before each shift, add 3 to every BCD nibble ≥ 5.
- Commit: after VALUE_W shifts, copy the BCD nibbles atomically into the display register, copy the pending flag to overflow, and clear busy.
- Display register holding rule: the register only changes at commit, so the scan never shows a partial result.
- Overflow display: with overflow=1, every digit shows a dash (7'b1000000). Blanking is not applied.
- Leading-zero blanking: with blank_lz=1, every digit above the most significant nonzero digit shows 7'b0000000. Digit 0 is never blanked, so a value of 0 shows "0".
- Scan: a refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances, going from NUM_DIGITS-1 to 0. an = 1 << index.
- Blink: a blink counter advances on each refresh wrap and toggles the blink phase every BLINK_TICKS wraps. When blink_en=1 and phase=off, seg=0 while an keeps scanning. When blink_en=0, the phase has no effect, but the counter keeps running.
- Decode: hex digits 0–9 use standard patterns. Nibbles A–F cannot occur and decode to blank.
- blank_lz and blink_en are sampled live each cycle.

## Timing
- Reset values:
  - busy=0, overflow=0, display register=0, index=0, refresh and blink counters=0, phase=on.
  - Outputs: an='b1, seg=7'b0111111 ("0").
- Latency:
  - load sampled at edge 0.
  - busy=1 from edge 0 through edge VALUE_W-1, i.e. VALUE_W cycles high.
  - Commit occurs at edge VALUE_W, and busy reads 0 after it.
  - seg reflects the new digit at edge VALUE_W+1, the registered decode stage.
- Back-to-back loads: load held high is accepted again on the first edge where busy=0, which is the cycle after commit.
- seg and an change on the same edge, so there is no cross-digit ghosting cycle.
- Reset mid-conversion: the conversion is abandoned and all state returns to its reset values. No partial commit occurs.
- Simultaneous commit and refresh wrap: the new index and the new digits both apply, and the decode uses the post-commit register.

## Structure
- Package seven_seg_pkg holds:
  - segment constants SEG_BLANK, SEG_DASH;
  - the digit-pattern function seg_decode(logic [3:0]) returning logic [6:0];
  - the BCD digit typedef bcd_t (logic [3:0]).
- Sub-module bin2bcd_seq, with parameters VALUE_W and NUM_DIGITS:
  - ports: start, value, busy, done pulse, bcd array, overflow;
  - contains the shift-add-3 engine and the range check.
- The top level holds the display register, refresh/blink counters, blanking mask and output registers.
- BCD width: the shift register is 4·NUM_DIGITS bits. Nibbles beyond NUM_DIGITS are not kept, because overflow covers that range.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, VALUE_W=14, REFRESH_DIV=4, BLINK_TICKS=2.
- Reset release:
  - an=0001 and seg=0111111.
  - an steps 0001→0010→0100→1000→0001 every 4 cycles.
- Load value=1234 with blank_lz=0:
  - busy high for exactly 14 cycles.
  - The scan then shows 4,3,2,1 on an bits 0..3 (seg 1100110, 1001111, 1011011, 0000110).
- Load value=7 with blank_lz=1:
  - digit 0 shows 0000111 and digits 1–3 show 0000000.
  - After a later load of 0, digit 0 shows 0111111.
- Load value=10000:
  - overflow=1 and all four digits show 1000000.
  - A following load of 9999 clears overflow and shows 9 (1101111) on every digit.
- Load while busy, then reset mid-conversion:
  - A second load during busy is ignored, and the first value is displayed.
  - rst_n pulsed low at conversion cycle 5 gives reset outputs and no commit.
- Blink with blink_en=1:
  - seg=0 for 8 cycles, then shows digits for 8 cycles, repeating.
  - an scans throughout.
